// File: rtl/regfile_2r2w.sv
// rtl/regfile_2r2w.sv - two-read/two-write register file with per-register busy scoreboard
// Optional feature macro REGFILE_BYPASS_EN forwards same-cycle write data to the read ports.
module regfile_2r2w #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 16,
  parameter int ZERO_REG = 0,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    ReadReg1,
  input  logic [AW-1:0]    ReadReg2,
  output logic [WIDTH-1:0] RegOut1,
  output logic [WIDTH-1:0] RegOut2,
  output logic             Busy1,
  output logic             Busy2,
  input  logic             WriteEnable1,
  input  logic             WriteEnable2,
  input  logic [AW-1:0]    WriteReg1,
  input  logic [AW-1:0]    WriteReg2,
  input  logic [WIDTH-1:0] WriteData1,
  input  logic [WIDTH-1:0] WriteData2,
  input  logic             IssueEnable,
  input  logic [AW-1:0]    IssueReg,
  output logic             AnyBusy
);

  logic [WIDTH-1:0] bank_q [DEPTH];
  logic [WIDTH-1:0] bank_d [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  logic wr1_ok;
  logic wr2_ok;
  logic iss_ok;

  function automatic logic hardwired(input logic [AW-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  assign wr1_ok = WriteEnable1 && !hardwired(WriteReg1);
  assign wr2_ok = WriteEnable2 && !hardwired(WriteReg2);
  assign iss_ok = IssueEnable && !hardwired(IssueReg);

  // Port 2 is applied after port 1 so it wins a collision; the issue is applied
  // last so a new producer keeps the register busy over a same-edge write.
  always_comb begin
    bank_d = bank_q;
    busy_d = busy_q;
    if (wr1_ok) begin
      bank_d[WriteReg1] = WriteData1;
      busy_d[WriteReg1] = 1'b0;
    end
    if (wr2_ok) begin
      bank_d[WriteReg2] = WriteData2;
      busy_d[WriteReg2] = 1'b0;
    end
    if (iss_ok) begin
      busy_d[IssueReg] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        bank_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      bank_q <= bank_d;
      busy_q <= busy_d;
    end
  end

  logic [AW-1:0] rd_addr [2];
  assign rd_addr[0] = ReadReg1;
  assign rd_addr[1] = ReadReg2;

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [WIDTH-1:0] data;
    logic             busy;

    always_comb begin
      data = bank_q[rd_addr[p]];
      busy = busy_q[rd_addr[p]];
`ifdef REGFILE_BYPASS_EN
      if (wr2_ok && (WriteReg2 == rd_addr[p])) begin
        data = WriteData2;
        busy = iss_ok && (IssueReg == rd_addr[p]);
      end else if (wr1_ok && (WriteReg1 == rd_addr[p])) begin
        data = WriteData1;
        busy = iss_ok && (IssueReg == rd_addr[p]);
      end
`endif
      // Reset and the hardwired zero register override everything, bypass included.
      if (!rst || hardwired(rd_addr[p])) begin
        data = '0;
        busy = 1'b0;
      end
    end
  end

  assign RegOut1 = g_rd[0].data;
  assign RegOut2 = g_rd[1].data;
  assign Busy1   = g_rd[0].busy;
  assign Busy2   = g_rd[1].busy;
  assign AnyBusy = |busy_q;

endmodule

// File: tb/tb_regfile_2r2w.sv
// tb/tb_regfile_2r2w.sv - self-checking bench for regfile_2r2w (default and zero-reg 32x32 instances)
module tb_regfile_2r2w;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [4:0]  ra1 [2];
  logic [4:0]  ra2 [2];
  logic [4:0]  wa1 [2];
  logic [4:0]  wa2 [2];
  logic [4:0]  ir  [2];
  logic        we1 [2];
  logic        we2 [2];
  logic        ie  [2];
  logic [31:0] wd1 [2];
  logic [31:0] wd2 [2];

  logic [15:0] a_out1, a_out2;
  logic        a_b1, a_b2, a_any;
  logic [31:0] z_out1, z_out2;
  logic        z_b1, z_b2, z_any;

  regfile_2r2w #(.WIDTH(16), .DEPTH(16), .ZERO_REG(0)) dut_a (
    .clk(clk), .rst(rst),
    .ReadReg1(ra1[0][3:0]), .ReadReg2(ra2[0][3:0]),
    .RegOut1(a_out1), .RegOut2(a_out2), .Busy1(a_b1), .Busy2(a_b2),
    .WriteEnable1(we1[0]), .WriteEnable2(we2[0]),
    .WriteReg1(wa1[0][3:0]), .WriteReg2(wa2[0][3:0]),
    .WriteData1(wd1[0][15:0]), .WriteData2(wd2[0][15:0]),
    .IssueEnable(ie[0]), .IssueReg(ir[0][3:0]), .AnyBusy(a_any)
  );

  regfile_2r2w #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1)) dut_z (
    .clk(clk), .rst(rst),
    .ReadReg1(ra1[1]), .ReadReg2(ra2[1]),
    .RegOut1(z_out1), .RegOut2(z_out2), .Busy1(z_b1), .Busy2(z_b2),
    .WriteEnable1(we1[1]), .WriteEnable2(we2[1]),
    .WriteReg1(wa1[1]), .WriteReg2(wa2[1]),
    .WriteData1(wd1[1]), .WriteData2(wd2[1]),
    .IssueEnable(ie[1]), .IssueReg(ir[1]), .AnyBusy(z_any)
  );

  // Reference model: what each register holds and whether a producer is pending.
  logic [31:0] mem [2][32];
  bit          bsy [2][32];
  int unsigned dep [2] = '{16, 32};
  logic [31:0] msk [2] = '{32'h0000_ffff, 32'hffff_ffff};
  bit          zr  [2] = '{1'b0, 1'b1};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 32; a++) begin
        mem[k][a] = '0;
        bsy[k][a] = 1'b0;
      end
  endfunction

  function automatic logic [31:0] exp_data(input int k, input logic [4:0] a);
    if (!rst || (zr[k] && a == 0)) return '0;
    if (BYP && we2[k] && wa2[k] == a) return wd2[k] & msk[k];
    if (BYP && we1[k] && wa1[k] == a) return wd1[k] & msk[k];
    return mem[k][a];
  endfunction

  function automatic logic exp_busy(input int k, input logic [4:0] a);
    if (!rst || (zr[k] && a == 0)) return 1'b0;
    if (BYP && ((we1[k] && wa1[k] == a) || (we2[k] && wa2[k] == a)))
      return ie[k] && ir[k] == a;
    return bsy[k][a];
  endfunction

  function automatic logic exp_any(input int k);
    for (int a = 0; a < int'(dep[k]); a++)
      if (bsy[k][a]) return 1'b1;
    return 1'b0;
  endfunction

  // Effect of one rising edge: writes land (port 2 last), then a pending issue marks busy.
  function automatic void model_edge();
    if (!rst) return;
    for (int k = 0; k < 2; k++) begin
      if (we1[k] && !(zr[k] && wa1[k] == 0)) begin
        mem[k][wa1[k]] = wd1[k] & msk[k];
        bsy[k][wa1[k]] = 1'b0;
      end
      if (we2[k] && !(zr[k] && wa2[k] == 0)) begin
        mem[k][wa2[k]] = wd2[k] & msk[k];
        bsy[k][wa2[k]] = 1'b0;
      end
      if (ie[k] && !(zr[k] && ir[k] == 0)) bsy[k][ir[k]] = 1'b1;
    end
  endfunction

  task automatic check_all(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_k%0d_out1", tag, k), (k == 0) ? {16'h0, a_out1} : z_out1, exp_data(k, ra1[k]));
      chk($sformatf("%s_k%0d_out2", tag, k), (k == 0) ? {16'h0, a_out2} : z_out2, exp_data(k, ra2[k]));
      chk($sformatf("%s_k%0d_busy1", tag, k), (k == 0) ? a_b1 : z_b1, exp_busy(k, ra1[k]));
      chk($sformatf("%s_k%0d_busy2", tag, k), (k == 0) ? a_b2 : z_b2, exp_busy(k, ra2[k]));
      chk($sformatf("%s_k%0d_any", tag, k), (k == 0) ? a_any : z_any, exp_any(k));
    end
  endtask

  task automatic step(input string tag);
    #1 check_all(tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    for (int k = 0; k < 2; k++) begin
      ra1[k] = '0; ra2[k] = '0; wa1[k] = '0; wa2[k] = '0; ir[k] = '0;
      we1[k] = 1'b0; we2[k] = 1'b0; ie[k] = 1'b0;
      wd1[k] = '0; wd2[k] = '0;
    end
  endtask

  function automatic logic [4:0] raddr(input int k);
    if ($urandom_range(0, 1) == 1) return 5'($urandom_range(0, 3));
    return 5'($urandom_range(0, dep[k] - 1));
  endfunction

  initial begin
    rst = 1'b0;
    model_clear();
    idle();
    @(negedge clk);

    // Writes and issues attempted while in reset must vanish.
    we1[0] = 1'b1; wa1[0] = 5'd3; wd1[0] = 32'h5a5a; ie[0] = 1'b1; ir[0] = 5'd3; ra1[0] = 5'd3;
    we2[1] = 1'b1; wa2[1] = 5'd6; wd2[1] = 32'h1357_9bdf; ra2[1] = 5'd6;
    step("in_reset");
    rst = 1'b1;
    idle();
    for (int a = 0; a < 16; a++) begin
      ra1[0] = 5'(a); ra2[0] = 5'(15 - a);
      #1;
      chk($sformatf("reset_r%0d_out1", a), {16'h0, a_out1}, 32'h0);
      chk($sformatf("reset_r%0d_out2", a), {16'h0, a_out2}, 32'h0);
      chk("reset_any", {31'h0, a_any}, 32'h0);
      @(negedge clk);
    end

    idle();
    we1[0] = 1'b1; wa1[0] = 5'd3; wd1[0] = 32'h1234;
    we2[0] = 1'b1; wa2[0] = 5'd7; wd2[0] = 32'habcd;
    step("dual_wr");
    idle();
    ra1[0] = 5'd3; ra2[0] = 5'd7;
    #1;
    chk("dual_r3", {16'h0, a_out1}, 32'h1234);
    chk("dual_r7", {16'h0, a_out2}, 32'habcd);
    step("dual_rd");

    idle();
    we1[0] = 1'b1; wa1[0] = 5'd5; wd1[0] = 32'h1111;
    we2[0] = 1'b1; wa2[0] = 5'd5; wd2[0] = 32'h2222;
    step("coll_wr");
    idle();
    ra1[0] = 5'd5;
    #1 chk("coll_r5", {16'h0, a_out1}, 32'h2222);
    step("coll_rd");

    idle();
    ie[0] = 1'b1; ir[0] = 5'd9; ra1[0] = 5'd9;
    step("sb_issue");
    idle();
    ra1[0] = 5'd9;
    #1;
    chk("sb_busy_c1", {31'h0, a_b1}, 32'h1);
    chk("sb_any_c1", {31'h0, a_any}, 32'h1);
    step("sb_c1");
    we1[0] = 1'b1; wa1[0] = 5'd9; wd1[0] = 32'h00ff; ra1[0] = 5'd9;
    #1;
    chk("sb_busy_c2", {31'h0, a_b1}, BYP ? 32'h0 : 32'h1);
    chk("sb_any_c2", {31'h0, a_any}, 32'h1);
    step("sb_c2");
    idle();
    ra1[0] = 5'd9;
    #1;
    chk("sb_busy_done", {31'h0, a_b1}, 32'h0);
    chk("sb_data_done", {16'h0, a_out1}, 32'h00ff);
    chk("sb_any_done", {31'h0, a_any}, 32'h0);
    step("sb_done");
    ie[0] = 1'b1; ir[0] = 5'd9; we2[0] = 1'b1; wa2[0] = 5'd9; wd2[0] = 32'h0a0a;
    step("sb_same");
    idle();
    ra1[0] = 5'd9;
    #1;
    chk("sb_same_busy", {31'h0, a_b1}, 32'h1);
    chk("sb_same_data", {16'h0, a_out1}, 32'h0a0a);
    step("sb_same_rd");

    idle();
    we1[0] = 1'b1; wa1[0] = 5'd2; wd1[0] = 32'h6666; ra1[0] = 5'd2;
    #1 chk("bypass_r2", {16'h0, a_out1}, BYP ? 32'h6666 : 32'h0);
    step("bypass");

    idle();
    we1[1] = 1'b1; wa1[1] = 5'd0; wd1[1] = 32'hffff; ie[1] = 1'b1; ir[1] = 5'd0; ra1[1] = 5'd0;
    step("zero_wr");
    idle();
    ra1[1] = 5'd0;
    #1;
    chk("zero_out", z_out1, 32'h0);
    chk("zero_busy", {31'h0, z_b1}, 32'h0);
    chk("zero_any", {31'h0, z_any}, 32'h0);
    we2[1] = 1'b1; wa2[1] = 5'd31; wd2[1] = 32'hdead_beef;
    step("wide_wr");
    idle();
    ra2[1] = 5'd31;
    #1 chk("wide_r31", z_out2, 32'hdead_beef);
    step("wide_rd");

    // Reset dropped mid-cycle discards the write in flight; the next edge writes.
    idle();
    we1[0] = 1'b1; wa1[0] = 5'd4; wd1[0] = 32'h4444;
    #2;
    rst = 1'b0;
    model_clear();
    #1 chk("midrst_any", {31'h0, a_any}, 32'h0);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    rst = 1'b1;
    ra1[0] = 5'd3;
    #1 chk("midrst_r3_cleared", {16'h0, a_out1}, 32'h0);
    ra1[0] = 5'd4;
    step("midrst_wr");
    idle();
    ra1[0] = 5'd4;
    #1 chk("midrst_r4", {16'h0, a_out1}, 32'h4444);
    step("midrst_rd");

    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 2; k++) begin
        ra1[k] = raddr(k); ra2[k] = raddr(k);
        wa1[k] = raddr(k); wa2[k] = raddr(k); ir[k] = raddr(k);
        we1[k] = ($urandom_range(0, 2) != 0);
        we2[k] = ($urandom_range(0, 2) != 0);
        ie[k]  = ($urandom_range(0, 2) == 0);
        wd1[k] = $urandom();
        wd2[k] = $urandom();
      end
      step("rnd");
    end

    idle();
    step("final");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
